// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Brief    : Shared AES constants, FSM encoding and round arithmetic helpers.
// Revision : 1.0
// ============================================================================
package aes_pkg;

    localparam logic [3:0] NR_AES128 = 4'd10;
    localparam logic [3:0] NR_AES192 = 4'd12;
    localparam logic [3:0] NR_AES256 = 4'd14;
    localparam int         BLK_BITS  = 128;
    localparam int         W_BITS    = 1920;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_RUN    = 1'b1;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Column byte 0 (row 0) sits in the MSBs.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Byte n lives at [127-8n -: 8]; byte n is row n%4 of column n/4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8*(4*c + row) -: 8] = s[127 - 8*(4*((c + row) % 4) + row) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic nr_supported(input logic [3:0] n);
        return (n == NR_AES128) || (n == NR_AES192) || (n == NR_AES256);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module   : aes_sbox
// Brief    : Combinational AES forward S-box (one byte).
// Revision : 1.0
// ============================================================================
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    // Entry 0 occupies the most significant byte.
    localparam logic [2047:0] c_sbox_table = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] w_base;

    assign w_base = 11'd2047 - {i_byte, 3'b000};
    assign o_byte = c_sbox_table[w_base -: 8];

endmodule
`default_nettype wire

// File: rtl/aes_round_engine.sv
`default_nettype none
// ============================================================================
// Module   : aes_round_engine
// Brief    : Iterative AES-128/192/256 encryptor, one round per clock.
// Revision : 1.0
// ============================================================================
module aes_round_engine #(
    parameter int W_BITS   = 1920,
    parameter int BLK_BITS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                key_valid,
    input  logic [3:0]          nr,
    input  logic [0:W_BITS-1]   w,
    input  logic [BLK_BITS-1:0] data_in,
    output logic                busy,
    output logic                done,
    output logic [BLK_BITS-1:0] data_out
);

    import aes_pkg::*;

    logic [0:0]          r_fsm;
    logic [3:0]          r_round;
    logic [3:0]          r_nr;
    logic [BLK_BITS-1:0] r_state;
    logic [BLK_BITS-1:0] r_data_out;
    logic                r_busy;
    logic                r_done;

    logic [10:0]         w_rk_base;
    logic [BLK_BITS-1:0] w_rk;
    logic [BLK_BITS-1:0] w_rk0;
    logic [BLK_BITS-1:0] w_sub;
    logic [BLK_BITS-1:0] w_shift;
    logic [BLK_BITS-1:0] w_mix;
    logic                w_accept;

    // The final round uses rk(nr_q), which equals rk(round) on that edge.
    assign w_rk_base = {r_round, 7'b0000000};
    assign w_rk      = w[w_rk_base +: BLK_BITS];
    assign w_rk0     = w[0 +: BLK_BITS];

    generate
        for (genvar i = 0; i < 16; i++) begin : g_sbox
            aes_sbox u_sbox (
                .i_byte (r_state[8*i +: 8]),
                .o_byte (w_sub[8*i +: 8])
            );
        end
    endgenerate

    assign w_shift = shift_rows(w_sub);

    generate
        for (genvar c = 0; c < 4; c++) begin : g_mix
            assign w_mix[BLK_BITS-1-32*c -: 32] = mix_column(w_shift[BLK_BITS-1-32*c -: 32]);
        end
    endgenerate

    assign w_accept = start && key_valid && nr_supported(nr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fsm      <= ST_IDLE;
            r_round    <= 4'd0;
            r_nr       <= 4'd0;
            r_state    <= '0;
            r_data_out <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_fsm)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= data_in ^ w_rk0;
                        r_nr    <= nr;
                        r_round <= 4'd1;
                        r_busy  <= 1'b1;
                        r_fsm   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (r_round == r_nr) begin
                        r_data_out <= w_shift ^ w_rk;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_fsm      <= ST_IDLE;
                    end else begin
                        r_state <= w_mix ^ w_rk;
                        r_round <= r_round + 4'd1;
                    end
                end
                default: r_fsm <= ST_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign data_out = r_data_out;

endmodule
`default_nettype wire
